// File: rtl/exp_inc_dec_pipe.sv
// exp_inc_dec_pipe: two-stage pipelined exponent adjust unit for the FP add/sub datapath.
// Adds or subtracts a step from a biased exponent, flags overflow (inf range) and
// underflow (zero/subnormal range), and optionally clamps the result.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  input handshake
//   in_exp               biased input exponent
//   in_op                00 pass, 01 add step, 10 subtract step, 11 add 1
//   in_step              unsigned step magnitude
//   out_valid/out_ready  output handshake
//   out_exp              adjusted exponent
//   out_ovf, out_unf     result >= MAX / result <= 0
module exp_inc_dec_pipe #(
  parameter int unsigned EXP_W    = 5,
  parameter int unsigned STEP_W   = EXP_W,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [1:0]        in_op,
  input  logic [STEP_W-1:0] in_step,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_ovf,
  output logic              out_unf
);

  // Two guard bits: one for carry past MAX, one as sign for borrow below zero.
  localparam int unsigned CalcW = ((STEP_W > EXP_W) ? STEP_W : EXP_W) + 2;
  localparam logic [EXP_W-1:0] MaxExp = '1;
  localparam logic [CalcW-1:0] OneC   = {{(CalcW-1){1'b0}}, 1'b1};
  localparam logic [CalcW-1:0] MaxC   = {{(CalcW-EXP_W){1'b0}}, MaxExp};

  // Stage 1 registers
  logic              r_s1_valid;
  logic [1:0]        r_s1_op;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [STEP_W-1:0] r_s1_step;

  // Stage 2 registers (drive the outputs directly)
  logic              r_s2_valid;
  logic [EXP_W-1:0]  r_s2_exp;
  logic              r_s2_ovf;
  logic              r_s2_unf;

  // Held low during reset and for the first edge after release.
  logic              r_rdy_en;

  logic              w_s2_adv;
  logic              w_in_ready;
  logic [CalcW-1:0]  w_a;
  logic [CalcW-1:0]  w_b;
  logic [CalcW-1:0]  w_sum;
  logic [EXP_W-1:0]  w_res_exp;
  logic              w_ovf;
  logic              w_unf;

  assign w_s2_adv   = !r_s2_valid | out_ready;
  assign w_in_ready = r_rdy_en & (!r_s1_valid | w_s2_adv);

  assign w_a = {{(CalcW-EXP_W){1'b0}}, r_s1_exp};
  assign w_b = {{(CalcW-STEP_W){1'b0}}, r_s1_step};

  always_comb begin
    w_sum     = w_a;
    w_res_exp = r_s1_exp;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    case (r_s1_op)
      2'b01:   w_sum = w_a + w_b;
      2'b10:   w_sum = w_a - w_b;
      2'b11:   w_sum = w_a + OneC;
      default: w_sum = w_a;
    endcase
    if (r_s1_op == 2'b00 || r_s1_exp == MaxExp) begin
      // Pass never flags; inf/NaN input stays inf/NaN for every op.
      w_res_exp = r_s1_exp;
    end else if (!w_sum[CalcW-1] && w_sum >= MaxC) begin
      w_ovf     = 1'b1;
      w_res_exp = SATURATE ? MaxExp : w_sum[EXP_W-1:0];
    end else if (w_sum[CalcW-1] || w_sum == '0) begin
      w_unf     = 1'b1;
      w_res_exp = SATURATE ? '0 : w_sum[EXP_W-1:0];
    end else begin
      w_res_exp = w_sum[EXP_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_exp   <= '0;
      r_s1_step  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_exp   <= '0;
      r_s2_ovf   <= 1'b0;
      r_s2_unf   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_op   <= in_op;
          r_s1_exp  <= in_exp;
          r_s1_step <= in_step;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_exp <= w_res_exp;
          r_s2_ovf <= w_ovf;
          r_s2_unf <= w_unf;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign out_exp   = r_s2_exp;
  assign out_ovf   = r_s2_ovf;
  assign out_unf   = r_s2_unf;

endmodule

// File: tb/tb_exp_inc_dec_pipe.sv
// Self-checking bench for exp_inc_dec_pipe: a saturating and a wrapping instance share
// stimulus; each is checked against a plain-integer reference model through a queue.
module tb_exp_inc_dec_pipe;
  localparam int EW = 5;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [EW-1:0] in_exp = '0;
  logic [1:0]    in_op = '0;
  logic [SW-1:0] in_step = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid, out_ovf, out_unf;
  logic [EW-1:0] out_exp;
  logic          in_ready_s0, out_valid_s0, out_ovf_s0, out_unf_s0;
  logic [EW-1:0] out_exp_s0;

  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] q1[$];
  logic [6:0] q0[$];
  logic acc_in;

  exp_inc_dec_pipe #(.EXP_W(EW), .STEP_W(SW), .SATURATE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_op(in_op), .in_step(in_step), .out_valid(out_valid),
    .out_ready(out_ready), .out_exp(out_exp), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  exp_inc_dec_pipe #(.EXP_W(EW), .STEP_W(SW), .SATURATE(1'b0)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s0),
    .in_exp(in_exp), .in_op(in_op), .in_step(in_step), .out_valid(out_valid_s0),
    .out_ready(out_ready), .out_exp(out_exp_s0), .out_ovf(out_ovf_s0), .out_unf(out_unf_s0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Returns {exp[4:0], ovf, unf}.
  function automatic logic [6:0] model(input int e, input int op, input int st, input bit sat);
    int r;
    logic [4:0] oe;
    bit ov;
    bit un;
    ov = 0;
    un = 0;
    if (op == 0 || e == 31) return {e[4:0], 2'b00};
    r = e;
    if (op == 1) r = e + st;
    if (op == 2) r = e - st;
    if (op == 3) r = e + 1;
    if (r >= 31) begin
      ov = 1;
      oe = sat ? 5'd31 : r[4:0];
    end else if (r <= 0) begin
      un = 1;
      oe = sat ? 5'd0 : r[4:0];
    end else begin
      oe = r[4:0];
    end
    return {oe, ov, un};
  endfunction

  // One clock: sample handshakes at negedge, update scoreboards, return #1 after posedge.
  task automatic cycle();
    logic a1, a0, v1, v0;
    logic [6:0] o1, o0, e;
    @(negedge clk);
    a1 = in_valid && in_ready;
    a0 = in_valid && in_ready_s0;
    v1 = out_valid && out_ready;
    v0 = out_valid_s0 && out_ready;
    o1 = {out_exp, out_ovf, out_unf};
    o0 = {out_exp_s0, out_ovf_s0, out_unf_s0};
    if (a1) q1.push_back(model(int'(in_exp), int'(in_op), int'(in_step), 1'b1));
    if (a0) q0.push_back(model(int'(in_exp), int'(in_op), int'(in_step), 1'b0));
    if (v1) begin
      if (q1.size() == 0) chk("spurious_out", 32'(out_valid), 0);
      else begin
        e = q1.pop_front();
        chk("out_exp", 32'(o1[6:2]), 32'(e[6:2]));
        chk("out_ovf", 32'(o1[1]), 32'(e[1]));
        chk("out_unf", 32'(o1[0]), 32'(e[0]));
      end
    end
    if (v0) begin
      if (q0.size() == 0) chk("s0_spurious_out", 32'(out_valid_s0), 0);
      else begin
        e = q0.pop_front();
        chk("s0_out_exp", 32'(o0[6:2]), 32'(e[6:2]));
        chk("s0_out_ovf", 32'(o0[1]), 32'(e[1]));
        chk("s0_out_unf", 32'(o0[0]), 32'(e[0]));
      end
    end
    @(posedge clk);
    #1;
    acc_in = a1;
  endtask

  task automatic send(input int e, input int op, input int st);
    int n;
    in_valid = 1'b1;
    in_exp   = e[EW-1:0];
    in_op    = op[1:0];
    in_step  = st[SW-1:0];
    n = 0;
    acc_in = 1'b0;
    while (!acc_in && n < 50) begin
      cycle();
      n++;
    end
    if (!acc_in) chk("send_timeout", 32'(acc_in), 1);
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q1.size() != 0 || q0.size() != 0 || out_valid) && n < 30) begin
      cycle();
      n++;
    end
    chk("drain_q1", 32'(q1.size()), 0);
    chk("drain_q0", 32'(q0.size()), 0);
  endtask

  int dir_e[11]  = '{30, 20, 20, 3, 5, 6, 31, 31, 31, 31, 0};
  int dir_op[11] = '{3, 1, 1, 2, 2, 2, 0, 1, 2, 3, 0};
  int dir_st[11] = '{0, 11, 13, 5, 5, 5, 3, 3, 3, 3, 0};

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_exp", 32'(out_exp), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    chk("rst_out_unf", 32'(out_unf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Latency: single beat 14 +1
    out_ready = 1'b1;
    send(14, 3, 0);
    in_valid = 1'b0;
    chk("lat_edge1_valid", 32'(out_valid), 0);
    cycle();
    chk("lat_edge2_valid", 32'(out_valid), 1);
    chk("lat_edge2_exp", 32'(out_exp), 15);
    cycle();

    // Back-to-back 14,15,16 -> consecutive outputs
    send(14, 3, 0);
    send(15, 3, 0);
    send(16, 3, 0);
    in_valid = 1'b0;
    chk("b2b_valid_a", 32'(out_valid), 1);
    chk("b2b_exp_a", 32'(out_exp), 16);
    cycle();
    chk("b2b_valid_b", 32'(out_valid), 1);
    chk("b2b_exp_b", 32'(out_exp), 17);
    cycle();
    chk("b2b_valid_end", 32'(out_valid), 0);

    // Overflow, underflow and special-input cases
    for (int i = 0; i < 11; i++) send(dir_e[i], dir_op[i], dir_st[i]);
    drain();

    // Backpressure: 1..6 pass with out_ready low for 4 cycles
    out_ready = 1'b0;
    send(1, 0, 0);
    send(2, 0, 0);
    chk("bp_in_ready_drop", 32'(in_ready), 0);
    chk("bp_exp_hold0", 32'(out_exp), 1);
    cycle();
    cycle();
    chk("bp_exp_hold1", 32'(out_exp), 1);
    chk("bp_valid_hold", 32'(out_valid), 1);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b1;
    for (int v = 3; v <= 6; v++) send(v, 0, 0);
    drain();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_exp    = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd31 : 5'($urandom_range(0, 31));
      in_op     = 2'($urandom_range(0, 3));
      in_step   = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(10, 0, 0);
    send(11, 0, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_exp", 32'(out_exp), 0);
    q1.delete();
    q0.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) begin
      rst_n = 1'b1;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 32'(in_ready), 1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("midrst_no_valid", 32'(out_valid), 0);
    end
    send(7, 1, 2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
